// File: rtl/adder_pkg.sv
// Shared types and helpers for the serial adder family.
package adder_pkg;

    // Controller states of the serial adder.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of beats (clock cycles in RUN) needed for one addition.
    function automatic int beats(input int width, input int slice);
        return width / slice;
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational SLICE-bit ripple-carry adder. c_msb is the carry into the
// top bit of the slice, used by the parent to derive signed overflow.
module adder_slice
    import adder_pkg::*;
#(
    parameter int SLICE = 1
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             c_in,
    output logic [SLICE-1:0] sum,
    output logic             c_out,
    output logic             c_msb
);

    logic [SLICE:0] cy;

    // Ripple the carry through each bit of the slice.
    always_comb begin
        cy    = '0;
        sum   = '0;
        cy[0] = c_in;
        for (int i = 0; i < SLICE; i++) begin
            sum[i]   = a[i] ^ b[i] ^ cy[i];
            cy[i+1]  = (a[i] & b[i]) | (cy[i] & (a[i] ^ b[i]));
        end
        c_out = cy[SLICE];
        c_msb = cy[SLICE-1];
    end

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder: sum = a + b + c_in computed SLICE bits per clock using a
// single ripple slice and a carry flop, with valid/ready on both sides.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for operands, in_ready high
//   RUN   | one slice added per cycle, cnt_q counts completed beats
//   DONE  | result presented on sum/c_out/overflow until out_ready
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SLICE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    localparam int            NBEATS    = beats(WIDTH, SLICE);
    localparam int            CW        = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(NBEATS - 1);

    generate
        if (WIDTH < 1 || SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_params
            $fatal(1, "serial_adder: SLICE (%0d) must divide WIDTH (%0d)", SLICE, WIDTH);
        end
    endgenerate

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_out_q, c_out_d;
    logic             ovf_q, ovf_d;

    logic [SLICE-1:0] slc_sum;
    logic             slc_cout;
    logic             slc_cmsb;
    logic [WIDTH-1:0] a_shr;
    logic [WIDTH-1:0] b_shr;
    logic [WIDTH-1:0] res_full;
    logic             accept;
    logic             run_beat;
    logic             last_beat;

    adder_slice #(.SLICE(SLICE)) u_slice (
        .a     (a_q[SLICE-1:0]),
        .b     (b_q[SLICE-1:0]),
        .c_in  (carry_q),
        .sum   (slc_sum),
        .c_out (slc_cout),
        .c_msb (slc_cmsb)
    );

    assign accept    = (state_q == IDLE) && in_valid;
    assign run_beat  = (state_q == RUN);
    assign last_beat = (cnt_q == LAST_BEAT);

    // The final slice goes straight to sum, so the partial-result register
    // only needs to hold the WIDTH-SLICE bits produced by earlier beats.
    generate
        if (SLICE == WIDTH) begin : g_single_beat
            assign a_shr    = '0;
            assign b_shr    = '0;
            assign res_full = slc_sum;
        end else begin : g_multi_beat
            logic [WIDTH-SLICE-1:0] part_q, part_d;

            assign a_shr    = {{SLICE{1'b0}}, a_q[WIDTH-1:SLICE]};
            assign b_shr    = {{SLICE{1'b0}}, b_q[WIDTH-1:SLICE]};
            assign res_full = {slc_sum, part_q};

            // Partial result shifts right; each new slice enters at the top.
            always_comb begin
                part_d = part_q;
                if (accept) begin
                    part_d = '0;
                end else if (run_beat) begin
                    part_d = res_full[WIDTH-1:SLICE];
                end
            end

            // Partial-result register.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    part_q <= '0;
                end else begin
                    part_q <= part_d;
                end
            end
        end
    endgenerate

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = c_in;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_shr;
                b_d     = b_shr;
                carry_d = slc_cout;
                cnt_d   = cnt_q + CW'(1);
                if (last_beat) begin
                    sum_d   = res_full;
                    c_out_d = slc_cout;
                    ovf_d   = slc_cout ^ slc_cmsb;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, operand, carry and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign c_out     = c_out_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: four instances (8/1, 8/4, 2/1, 2/2).
// Drivers push expected results; a negedge monitor pops on each transfer.
module tb_serial_adder;
    import adder_pkg::*;

    typedef struct packed {
        logic [8:0] cs;
        logic       ovf;
    } exp_t;

    localparam int WW [4] = '{8, 8, 2, 2};
    localparam int SS [4] = '{1, 4, 1, 2};

    logic             clk = 1'b0;
    logic             rst_n;
    logic [3:0]       iv, ordy, ci;
    logic [3:0]       ir, ov, co, of;
    logic [7:0]       av [4];
    logic [7:0]       bv [4];
    logic [3:0][7:0]  sm;
    logic [1:0]       sm2, sm3;

    exp_t exp_q [4][$];
    int   acc_cyc [4];
    logic ov_prev [4];
    int   cyc = 0;
    int   passed = 0;
    int   total = 0;
    bit   rnd_rdy = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_adder #(.WIDTH(8), .SLICE(1)) u_w8s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(av[0]), .b(bv[0]), .c_in(ci[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
        .sum(sm[0]), .c_out(co[0]), .overflow(of[0]));
    serial_adder #(.WIDTH(8), .SLICE(4)) u_w8s4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(av[1]), .b(bv[1]), .c_in(ci[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
        .sum(sm[1]), .c_out(co[1]), .overflow(of[1]));
    serial_adder #(.WIDTH(2), .SLICE(1)) u_w2s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
        .a(av[2][1:0]), .b(bv[2][1:0]), .c_in(ci[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
        .sum(sm2), .c_out(co[2]), .overflow(of[2]));
    serial_adder #(.WIDTH(2), .SLICE(2)) u_w2s2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]),
        .a(av[3][1:0]), .b(bv[3][1:0]), .c_in(ci[3]), .out_valid(ov[3]), .out_ready(ordy[3]),
        .sum(sm3), .c_out(co[3]), .overflow(of[3]));

    assign sm[2] = {6'd0, sm2};
    assign sm[3] = {6'd0, sm3};

    task automatic check(input string name, input int k, input logic [31:0] act,
                         input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s [dut %0d] at cycle %0d: got %0h, expected %0h",
                      name, k, cyc, act, req);
    endtask

    task automatic timeout(input string name, input int k);
        total++;
        $display("FAIL %s [dut %0d]: timed out at cycle %0d", name, k, cyc);
    endtask

    // Reference for the exhaustive runs: exact sum plus signed-overflow rule.
    function automatic exp_t model(input int w, input logic [7:0] a, input logic [7:0] b,
                                   input logic c);
        exp_t       e;
        logic [8:0] s;
        s     = {1'b0, a} + {1'b0, b} + {8'd0, c};
        e.cs  = s;
        e.ovf = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
        return e;
    endfunction

    task automatic send(input int k, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input exp_t e, input bit push_exp);
        bit ok = 1'b0;
        @(posedge clk);
        #1;
        av[k] = a; bv[k] = b; ci[k] = c; iv[k] = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (ir[k]) begin
                @(posedge clk);
                #1;
                iv[k] = 1'b0;
                acc_cyc[k] = cyc;
                if (push_exp) exp_q[k].push_back(e);
                ok = 1'b1;
            end
        end
        if (!ok) begin
            iv[k] = 1'b0;
            timeout("accept", k);
        end
    endtask

    // Monitor: latency on each out_valid rise, result on each output transfer.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rst_n && ov[k] && !ov_prev[k])
                check("latency", k, cyc - acc_cyc[k], beats(WW[k], SS[k]));
            if (rst_n && ov[k] && ordy[k]) begin
                if (exp_q[k].size() == 0) begin
                    total++;
                    $display("FAIL unexpected_result [dut %0d]: got %0h with no expectation",
                             k, sm[k]);
                end else begin
                    exp_t e;
                    e = exp_q[k].pop_front();
                    check("c_out_sum", k, 32'(({1'b0, sm[k]}) | (9'(co[k]) << WW[k])), 32'(e.cs));
                    check("overflow", k, 32'(of[k]), 32'(e.ovf));
                end
            end
            ov_prev[k] = rst_n ? ov[k] : 1'b0;
        end
    end

    // Random consumer backpressure on the 2-bit instances.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_rdy) begin
                ordy[2] = 1'($urandom_range(0, 1));
                ordy[3] = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic exhaustive(input int k);
        for (int v = 0; v < 32; v++) begin
            logic [7:0] a, b;
            logic       c;
            a = 8'(v[4:3]);
            b = 8'(v[2:1]);
            c = v[0];
            repeat ($urandom_range(0, 3)) @(posedge clk);
            send(k, a, b, c, model(2, a, b, c), 1'b1);
        end
    endtask

    // Directed vectors: {a, b, c_in, expected {c_out,sum}, expected overflow}.
    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic [8:0] cs;
        logic       ovf;
    } vec_t;

    vec_t v8s1 [5] = '{
        '{8'hFF, 8'h01, 1'b0, 9'h100, 1'b0},
        '{8'h7F, 8'h01, 1'b0, 9'h080, 1'b1},
        '{8'h80, 8'h80, 1'b1, 9'h101, 1'b1},
        '{8'h00, 8'h00, 1'b0, 9'h000, 1'b0},
        '{8'hA5, 8'h5A, 1'b1, 9'h100, 1'b0}
    };
    vec_t v8s4 [4] = '{
        '{8'h3C, 8'h5A, 1'b1, 9'h097, 1'b1},
        '{8'hFF, 8'hFF, 1'b1, 9'h1FF, 1'b0},
        '{8'h0F, 8'h01, 1'b0, 9'h010, 1'b0},
        '{8'h40, 8'h40, 1'b0, 9'h080, 1'b1}
    };

    initial begin
        bit   seen;
        exp_t e;

        rst_n = 1'b0;
        iv    = '0;
        ci    = '0;
        ordy  = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            av[k] = '0; bv[k] = '0; acc_cyc[k] = 0; ov_prev[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check("rst_in_ready", k, 32'(ir[k]), 32'd1);
            check("rst_out_valid", k, 32'(ov[k]), 32'd0);
            check("rst_sum", k, 32'(sm[k]), 32'd0);
            check("rst_c_out", k, 32'(co[k]), 32'd0);
            check("rst_overflow", k, 32'(of[k]), 32'd0);
        end
        rst_n = 1'b1;

        foreach (v8s1[i]) begin
            e.cs = v8s1[i].cs; e.ovf = v8s1[i].ovf;
            send(0, v8s1[i].a, v8s1[i].b, v8s1[i].c, e, 1'b1);
        end
        foreach (v8s4[i]) begin
            e.cs = v8s4[i].cs; e.ovf = v8s4[i].ovf;
            send(1, v8s4[i].a, v8s4[i].b, v8s4[i].c, e, 1'b1);
        end

        // Backpressure: hold the result for 5 cycles with a new request pending.
        ordy[0] = 1'b0;
        e.cs = 9'h101; e.ovf = 1'b1;
        send(0, 8'h80, 8'h80, 1'b1, e, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = ov[0];
        end
        if (!seen) timeout("bp_out_valid", 0);
        av[0] = 8'h11; bv[0] = 8'h22; ci[0] = 1'b0; iv[0] = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("bp_out_valid", 0, 32'(ov[0]), 32'd1);
            check("bp_in_ready", 0, 32'(ir[0]), 32'd0);
            check("bp_sum", 0, 32'(sm[0]), 32'h01);
            check("bp_c_out", 0, 32'(co[0]), 32'd1);
            check("bp_overflow", 0, 32'(of[0]), 32'd1);
        end
        @(posedge clk);
        #1;
        iv[0]   = 1'b0;
        ordy[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_back_idle", 0, 32'(ir[0]), 32'd1);
        check("bp_valid_drop", 0, 32'(ov[0]), 32'd0);
        check("bp_sum_kept", 0, 32'(sm[0]), 32'h01);
        repeat (2) @(negedge clk);
        check("bp_not_queued", 0, 32'(ir[0]), 32'd1);

        // Reset at beat 3 of 8: outputs drop to reset values at once.
        send(0, 8'hAA, 8'h55, 1'b0, e, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrun_rst_in_ready", 0, 32'(ir[0]), 32'd1);
        check("midrun_rst_out_valid", 0, 32'(ov[0]), 32'd0);
        check("midrun_rst_sum", 0, 32'(sm[0]), 32'd0);
        check("midrun_rst_c_out", 0, 32'(co[0]), 32'd0);
        check("midrun_rst_overflow", 0, 32'(of[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        e.cs = 9'h002; e.ovf = 1'b0;
        send(0, 8'h01, 8'h01, 1'b0, e, 1'b1);

        // Exhaustive 2-bit runs with random gaps and random out_ready.
        rnd_rdy = 1'b1;
        fork
            exhaustive(2);
            exhaustive(3);
        join

        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            seen = (exp_q[0].size() == 0) && (exp_q[1].size() == 0) &&
                   (exp_q[2].size() == 0) && (exp_q[3].size() == 0);
        end
        if (!seen) timeout("drain", 0);
        rnd_rdy = 1'b0;
        for (int k = 0; k < 4; k++)
            check("queue_empty", k, 32'(exp_q[k].size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
